load_store_unit: RTL and testbench

//  Memory-side initiator between the CPU datapath and the data memory (DM).
//  - Accepts one load/store request at a time from the core.
//  - Issues aligned word accesses to DM; DM is big-endian, reads combinationally and writes on negedge clk.
//  - Implements lb/lbu/lh/lhu/lw plus sw directly; implements sb/sh by read-modify-write.
//  - Returns one response per request, carrying data or a fault flag.

---
 rtl/load_store_unit_pkg.sv | 21 ++
 rtl/load_store_unit_lane.sv | 49 ++++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access size codes, FSM states and the default DM size.
package load_store_unit_pkg;

  localparam int unsigned MEM_BYTES_DEF = 128;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_lane.sv
// Big-endian lane logic: extracts and extends load data, merges sub-word store data into a read word.
module lsu_lane
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  lsu_size_e   size_i,
  input  logic        uns_i,
  output logic [31:0] ldata_o,
  output logic [31:0] merged_o
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] bmask;
  logic [31:0] hmask;

  // Big-endian: offset k sits (3-k) bytes up from the LSB, and 3-k == ~k for two bits.
  assign bsh = {~off_i, 3'b000};
  assign hsh = {~off_i[1], 4'b0000};

  always_comb begin
    byte_v   = 8'(rword_i >> bsh);
    half_v   = 16'(rword_i >> hsh);
    bmask    = 32'h0000_00FF << bsh;
    hmask    = 32'h0000_FFFF << hsh;
    ldata_o  = '0;
    merged_o = rword_i;
    unique case (size_i)
      SZ_B: begin
        ldata_o  = uns_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        merged_o = (rword_i & ~bmask) | ({24'h0, wdata_i[7:0]} << bsh);
      end
      SZ_H: begin
        ldata_o  = uns_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        merged_o = (rword_i & ~hmask) | ({16'h0, wdata_i[15:0]} << hsh);
      end
      SZ_W: begin
        ldata_o  = rword_i;
        merged_o = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store initiator to a big-endian word DM; sub-word stores use read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] Mem_addr,
  output logic [31:0] Mem_w_data,
  output logic        Mem_w,
  output logic        Mem_r,
  input  logic [31:0] Mem_r_data
);

  lsu_state_e  state_q;
  lsu_size_e   size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] wword_q;
  logic [31:0] rdata_q;
  logic        err_q;

  lsu_size_e   req_size_e;
  logic        fault;
  logic [31:0] ldata;
  logic [31:0] merged;

  assign req_size_e = lsu_size_e'(req_size);

  always_comb begin
    fault = (req_size_e == SZ_X)
          | ((req_size_e == SZ_H) & req_addr[0])
          | ((req_size_e == SZ_W) & (|req_addr[1:0]))
          | (req_addr >= MEM_BYTES);
  end

  lsu_lane u_lane (
    .rword_i  (Mem_r_data),
    .wdata_i  (wdata_q),
    .off_i    (addr_q[1:0]),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .ldata_o  (ldata),
    .merged_o (merged)
  );

  // Response fields are only written on entry to RESP so they hold between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wword_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            size_q  <= req_size_e;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (fault) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end else if (!req_we) begin
              state_q <= ST_LOAD;
            end else if (req_size_e == SZ_W) begin
              wword_q <= req_wdata;
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_RMW_RD;
            end
          end
        end
        ST_LOAD: begin
          rdata_q <= ldata;
          err_q   <= 1'b0;
          state_q <= ST_RESP;
        end
        ST_RMW_RD: begin
          wword_q <= merged;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign Mem_r      = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
  assign Mem_w      = (state_q == ST_WRITE);
  assign Mem_addr   = {addr_q[31:2], 2'b00};
  assign Mem_w_data = wword_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a big-endian byte-array DM model (negedge writes).
module tb_load_store_unit;

  localparam int unsigned MB = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] Mem_addr;
  logic [31:0] Mem_w_data;
  logic        Mem_w;
  logic        Mem_r;
  logic [31:0] Mem_r_data;

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .Mem_addr     (Mem_addr),
    .Mem_w_data   (Mem_w_data),
    .Mem_w        (Mem_w),
    .Mem_r        (Mem_r),
    .Mem_r_data   (Mem_r_data)
  );

  always #5 clk = ~clk;

  logic [7:0] dm [MB];
  logic [7:0] rm [MB];
  logic [6:0] ma;

  assign ma = {Mem_addr[6:2], 2'b00};
  assign Mem_r_data = {dm[ma], dm[ma | 7'd1], dm[ma | 7'd2], dm[ma | 7'd3]};

  always @(negedge clk) begin
    if (Mem_w) begin
      dm[ma]         <= Mem_w_data[31:24];
      dm[ma | 7'd1]  <= Mem_w_data[23:16];
      dm[ma | 7'd2]  <= Mem_w_data[15:8];
      dm[ma | 7'd3]  <= Mem_w_data[7:0];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nr;
    int          nw;
    int          c0;
    logic [31:0] maddr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   nr = 0;
  int   nw = 0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] dm_word(input logic [6:0] a);
    return {dm[a], dm[a + 7'd1], dm[a + 7'd2], dm[a + 7'd3]};
  endfunction

  function automatic logic [31:0] model_ld(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
    logic [6:0]  a;
    logic [7:0]  b;
    logic [15:0] h;
    a = addr[6:0];
    b = rm[a];
    h = {rm[a], rm[a + 7'd1]};
    case (sz)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return {rm[a], rm[a + 7'd1], rm[a + 7'd2], rm[a + 7'd3]};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      nr = 0;
      nw = 0;
    end else begin
      if ((Mem_r || Mem_w) && exp_q.size() > 0)
        check_eq("mem_addr", Mem_addr, exp_q[0].maddr);
      if (Mem_r) nr++;
      if (Mem_w) nw++;
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_resp", {31'h0, resp_valid}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("rdata",   resp_rdata, e.rdata);
          check_eq("err",     {31'h0, resp_err}, {31'h0, e.err});
          check_eq("latency", 32'(cyc - e.c0), 32'(e.lat));
          check_eq("n_mem_r", 32'(nr), 32'(e.nr));
          check_eq("n_mem_w", 32'(nw), 32'(e.nw));
        end
        nr = 0;
        nw = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    exp_t e;
    int unsigned n;
    logic flt;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check_eq("ready_timeout", {31'h0, req_ready}, 32'h1);
      return;
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    flt = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00) || (addr >= MB);
    e.c0    = cyc;
    e.maddr = {addr[31:2], 2'b00};
    e.err   = flt;
    e.rdata = '0;
    if (flt) begin
      e.lat = 1; e.nr = 0; e.nw = 0;
    end else if (!we) begin
      e.lat = 2; e.nr = 1; e.nw = 0;
      e.rdata = model_ld(addr, sz, uns);
    end else begin
      if (sz == 2'b10) begin
        e.lat = 2; e.nr = 0; e.nw = 1;
        rm[addr[6:0]]        = wd[31:24];
        rm[addr[6:0] + 7'd1] = wd[23:16];
        rm[addr[6:0] + 7'd2] = wd[15:8];
        rm[addr[6:0] + 7'd3] = wd[7:0];
      end else begin
        e.lat = 3; e.nr = 1; e.nw = 1;
        if (sz == 2'b00) rm[addr[6:0]] = wd[7:0];
        else begin
          rm[addr[6:0]]        = wd[15:8];
          rm[addr[6:0] + 7'd1] = wd[7:0];
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_eq("ready_busy", {31'h0, req_ready}, 32'h0);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < int'(MB); i++) begin
      dm[i] = 8'h00;
      rm[i] = 8'h00;
    end
    {dm[8], dm[9], dm[10], dm[11]}     = 32'h1122_A244;
    {dm[124], dm[125], dm[126], dm[127]} = 32'hDEAD_BEEF;
    {rm[8], rm[9], rm[10], rm[11]}     = 32'h1122_A244;
    {rm[124], rm[125], rm[126], rm[127]} = 32'hDEAD_BEEF;

    #2;
    check_eq("rst_ready",  {31'h0, req_ready}, 32'h1);
    check_eq("rst_rvalid", {31'h0, resp_valid}, 32'h0);
    check_eq("rst_rdata",  resp_rdata, 32'h0);
    check_eq("rst_err",    {31'h0, resp_err}, 32'h0);
    check_eq("rst_mem_rw", {30'h0, Mem_r, Mem_w}, 32'h0);
    check_eq("rst_maddr",  Mem_addr, 32'h0);
    check_eq("rst_mwdata", Mem_w_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h0A, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h0A, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, 1'b0);

    issue(1'b1, 2'b00, 1'b0, 32'h0A, 32'h0000_00EE, 1'b0);
    drain();
    check_eq("dm_word8", dm_word(7'd8), 32'h1122_EE44);

    issue(1'b1, 2'b01, 1'b0, 32'h7E, 32'h0000_1234, 1'b0);
    drain();
    check_eq("dm_word124", dm_word(7'd124), 32'hDEAD_1234);
    issue(1'b1, 2'b10, 1'b0, 32'h80, 32'h5555_5555, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h7C, 32'h0, 1'b0);

    issue(1'b0, 2'b01, 1'b0, 32'h09, 32'h0, 1'b0);
    issue(1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h7D, 32'h0, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hA5A5_5A5A, 1'b1);
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFF_FF3C, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
    drain();
    check_eq("dm_word16", dm_word(7'd16), 32'hA5A5_5A3C);

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h08;
    req_wdata = 32'hCAFE_BABE;
    @(posedge clk);
    #1;
    check_eq("abort_memw_pre", {31'h0, Mem_w}, 32'h1);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("abort_memw_drop", {31'h0, Mem_w}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("abort_ready", {31'h0, req_ready}, 32'h1);
    check_eq("abort_rvalid", {31'h0, resp_valid}, 32'h0);
    check_eq("abort_dm_word8", dm_word(7'd8), 32'h1122_EE44);

    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1);
  end

endmodule
